mmio_bridge_mc: RTL and testbench

- Parametrised successor to the single-cycle CPU data-bus bridge.
- Routes one CPU data-port transaction to one of NUM_DEV memory-mapped targets (DM, TC0, TC1, further peripherals) via a base/mask decode table.
- Each transaction is a registered req/ready handshake, so targets may take multiple cycles.
- Adds bus-error reporting for unmapped addresses and an optional no-ack timeout. Sits between the CPU M-stage and the DM/timer/peripheral set.

---
 rtl/mmio_bridge_mc_pkg.sv | 43 ++++
 rtl/mmio_bridge_mc_if.sv | 31 +++
 rtl/mmio_bridge_mc_decode.sv | 25 ++
 rtl/mmio_bridge_mc.sv | 146 ++++++++++++++
 tb/tb_mmio_bridge_mc.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_bridge_mc_pkg.sv
// Shared types and default address map for the multi-cycle MMIO bridge.
// Holds the FSM state encoding and the priority decode helper.
package mmio_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int MAX_DEV = 8;
    localparam int TBL_W   = MAX_DEV * 32;

    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DM_MASK  = 32'hffff_c000;
    localparam logic [31:0] TC0_BASE = 32'h0000_7f00;
    localparam logic [31:0] TC0_MASK = 32'hffff_fff0;
    localparam logic [31:0] TC1_BASE = 32'h0000_7f10;
    localparam logic [31:0] TC1_MASK = 32'hffff_fff0;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } dec_t;

    // Walks from the top entry down so the lowest matching index is the last write.
    function automatic dec_t match_table(input logic [31:0]      addr,
                                         input logic [TBL_W-1:0] base,
                                         input logic [TBL_W-1:0] mask,
                                         input int               num);
        dec_t r;
        r = '0;
        for (int i = MAX_DEV - 1; i >= 0; i--) begin
            if (i < num && (addr & mask[i*32 +: 32]) == base[i*32 +: 32]) begin
                r.hit = 1'b1;
                r.idx = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_bridge_mc_if.sv
// CPU-side and device-side bus bundles for the MMIO bridge.
// Handshake: the CPU holds cpu_req and all request fields until the one-cycle cpu_ready pulse; targets answer with a one-cycle dev_ack while selected.
interface mmio_cpu_if #(parameter int DW = 32);
    logic            cpu_req;
    logic [31:0]     cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic [DW/8-1:0] cpu_byteen;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_ready;
    logic            cpu_err;

    modport master (output cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
                    input  cpu_rdata, cpu_ready, cpu_err);
    modport slave  (input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
                    output cpu_rdata, cpu_ready, cpu_err);
endinterface

interface mmio_dev_if #(parameter int NUM_DEV = 3, parameter int DW = 32);
    logic [NUM_DEV-1:0]    dev_sel;
    logic [31:0]           dev_addr;
    logic [DW-1:0]         dev_wdata;
    logic [DW/8-1:0]       dev_byteen;
    logic                  dev_we;
    logic [NUM_DEV*DW-1:0] dev_rdata;
    logic [NUM_DEV-1:0]    dev_ack;

    modport master (output dev_sel, dev_addr, dev_wdata, dev_byteen, dev_we,
                    input  dev_rdata, dev_ack);
    modport slave  (input  dev_sel, dev_addr, dev_wdata, dev_byteen, dev_we,
                    output dev_rdata, dev_ack);
endinterface

// File: rtl/mmio_bridge_mc_decode.sv
// Combinational base/mask address decoder; lowest matching index wins.
module mmio_addr_decode
    import mmio_bridge_pkg::*;
#(
    parameter int                   NUM_DEV  = 3,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE = {TC1_BASE, TC0_BASE, DM_BASE},
    parameter logic [NUM_DEV*32-1:0] DEV_MASK = {TC1_MASK, TC0_MASK, DM_MASK}
) (
    input  logic [31:0] addr_i,
    output logic        hit_o,
    output logic [2:0]  idx_o
);

    localparam logic [TBL_W-1:0] BASE_EXT = TBL_W'(DEV_BASE);
    localparam logic [TBL_W-1:0] MASK_EXT = TBL_W'(DEV_MASK);

    dec_t dec;

    always_comb begin
        dec   = match_table(addr_i, BASE_EXT, MASK_EXT, NUM_DEV);
        hit_o = dec.hit;
        idx_o = dec.idx;
    end

endmodule

// File: rtl/mmio_bridge_mc.sv
// Multi-cycle CPU data-bus bridge: decodes one request, holds it on the device bus until ack.
// Optional no-ack timeout is enabled with BRIDGE_TIMEOUT_EN.
module mmio_bridge_mc
    import mmio_bridge_pkg::*;
#(
    parameter int                    NUM_DEV  = 3,
    parameter int                    DW       = 32,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE = {TC1_BASE, TC0_BASE, DM_BASE},
    parameter logic [NUM_DEV*32-1:0] DEV_MASK = {TC1_MASK, TC0_MASK, DM_MASK},
    parameter int                    TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    mmio_cpu_if.slave         cpu,
    mmio_dev_if.master        dev,
    output state_t            state_o
);

    if (NUM_DEV < 1 || NUM_DEV > MAX_DEV || TIMEOUT < 2) begin : g_param_check
        $error("mmio_bridge_mc: parameter out of range");
    end

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [DW/8-1:0]    be_q, be_d;
    logic [2:0]         idx_q, idx_d;
    logic [DW-1:0]      rdata_q, rdata_d;

    logic               dec_hit;
    logic [2:0]         dec_idx;
    logic [NUM_DEV-1:0] sel_vec;
    logic [DW-1:0]      sel_rdata;
    logic               ack_hit;

    mmio_addr_decode #(
        .NUM_DEV  (NUM_DEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_decode (
        .addr_i (cpu.cpu_addr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    assign sel_vec = NUM_DEV'(1) << idx_q;
    assign ack_hit = |(dev.dev_ack & sel_vec);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel_vec[i]) sel_rdata = sel_rdata | dev.dev_rdata[i*DW +: DW];
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          timed_out;

    // Saturating count of BUSY cycles; the check looks at the post-increment value.
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    assign timed_out = (cnt_inc >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
`ifdef BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cpu.cpu_req) begin
                    addr_d  = cpu.cpu_addr;
                    wdata_d = cpu.cpu_wdata;
                    be_d    = cpu.cpu_byteen;
                    idx_d   = dec_idx;
                    rdata_d = '0;
                    state_d = dec_hit ? BUSY : ERR;
`ifdef BRIDGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
`ifdef BRIDGE_TIMEOUT_EN
                cnt_d = cnt_inc;
`endif
                if (ack_hit) begin
                    // Writes return zero data.
                    rdata_d = (|be_q) ? '0 : sel_rdata;
                    state_d = RESP;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (timed_out) begin
                    state_d = ERR;
                end
`endif
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cpu.cpu_ready  = (state_q == RESP) || (state_q == ERR);
    assign cpu.cpu_err    = (state_q == ERR);
    assign cpu.cpu_rdata  = (state_q == RESP) ? rdata_q : '0;

    assign dev.dev_sel    = (state_q == BUSY) ? sel_vec : '0;
    assign dev.dev_addr   = addr_q;
    assign dev.dev_wdata  = wdata_q;
    assign dev.dev_byteen = be_q;
    assign dev.dev_we     = |be_q;

    assign state_o = state_q;

endmodule

// File: tb/tb_mmio_bridge_mc.sv
// Directed bench for mmio_bridge_mc: table of single transactions plus reset, stray-ack and timeout sequences.
module tb_mmio_bridge_mc;
    import mmio_bridge_pkg::*;

    localparam int NUM_DEV = 3;
    localparam int DW      = 32;
    localparam int NVEC    = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mmio_cpu_if #(.DW(DW)) cpu ();
    mmio_dev_if #(.NUM_DEV(NUM_DEV), .DW(DW)) dev ();
    state_t state;

    mmio_bridge_mc #(.NUM_DEV(NUM_DEV), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cpu     (cpu),
        .dev     (dev),
        .state_o (state)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_at;
        logic [31:0] drdata;
        logic [2:0]  exp_sel;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[NVEC];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every slice carries distinct filler so a wrong-slice capture shows up.
    task automatic set_ack(input int tgt, input logic [31:0] d);
        dev.dev_ack = '0;
        for (int i = 0; i < NUM_DEV; i++) dev.dev_rdata[i*DW +: DW] = 32'(32'h1111_1111 * (i + 1));
        if (tgt >= 0) begin
            dev.dev_ack[tgt] = 1'b1;
            dev.dev_rdata[tgt*DW +: DW] = d;
        end
    endtask

    function automatic int sel_idx(input logic [2:0] s);
        for (int i = 0; i < 3; i++) if (s[i]) return i;
        return -1;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int c;
        int tgt;
        bit done;
        tgt = sel_idx(v.exp_sel);
        exp_q.push_back(v.exp_rdata);
        cpu.cpu_req    = 1'b1;
        cpu.cpu_addr   = v.addr;
        cpu.cpu_wdata  = v.wdata;
        cpu.cpu_byteen = v.be;
        set_ack(-1, '0);
        c = 0;
        done = 1'b0;
        while (!done && c < 100) begin
            step();
            c++;
            set_ack(-1, '0);
            if (cpu.cpu_ready) begin
                done = 1'b1;
            end else begin
                check({tag, "_sel"},    32'(dev.dev_sel), 32'(v.exp_sel));
                check({tag, "_addr"},   dev.dev_addr, v.addr);
                check({tag, "_byteen"}, 32'(dev.dev_byteen), 32'(v.be));
                check({tag, "_we"},     32'(dev.dev_we), 32'(v.be != 4'h0));
                if (v.be != 4'h0) check({tag, "_wdata"}, dev.dev_wdata, v.wdata);
                if (c == v.ack_at) set_ack(tgt, v.drdata);
            end
        end
        cpu.cpu_req = 1'b0;
        if (!done) begin
            check({tag, "_budget"}, 32'(c), 32'(v.exp_lat));
            void'(exp_q.pop_front());
        end else begin
            check({tag, "_latency"}, 32'(c), 32'(v.exp_lat));
            check({tag, "_err"},     32'(cpu.cpu_err), 32'(v.exp_err));
            check({tag, "_rdata"},   cpu.cpu_rdata, exp_q.pop_front());
            check({tag, "_sel_off"}, 32'(dev.dev_sel), 32'h0);
        end
        step();
        check({tag, "_idle"}, 32'(state), 32'(IDLE));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  32'(cpu.cpu_ready), 32'h0);
        check({tag, "_err"},    32'(cpu.cpu_err), 32'h0);
        check({tag, "_rdata"},  cpu.cpu_rdata, 32'h0);
        check({tag, "_sel"},    32'(dev.dev_sel), 32'h0);
        check({tag, "_addr"},   dev.dev_addr, 32'h0);
        check({tag, "_wdata"},  dev.dev_wdata, 32'h0);
        check({tag, "_byteen"}, 32'(dev.dev_byteen), 32'h0);
        check({tag, "_we"},     32'(dev.dev_we), 32'h0);
        check({tag, "_state"},  32'(state), 32'(IDLE));
    endtask

    initial begin
        int early;

        //          addr          wdata         be    ack drdata        sel     err rdata         lat
        vecs[0] = '{32'h0000_0010, 32'h0,        4'h0, 1, 32'hDEAD_BEEF, 3'b001, 0, 32'hDEAD_BEEF, 2};
        vecs[1] = '{32'h0000_7f04, 32'h0000_0009, 4'hF, 3, 32'h1234_5678, 3'b010, 0, 32'h0,        4};
        vecs[2] = '{32'h0000_9000, 32'h0,        4'h0, 0, 32'h0,        3'b000, 1, 32'h0,        1};
        vecs[3] = '{32'h0000_7f1c, 32'h0,        4'h0, 2, 32'hA5A5_0001, 3'b100, 0, 32'hA5A5_0001, 3};
        vecs[4] = '{32'h0000_3ffc, 32'h0000_CAFE, 4'h3, 1, 32'h7777_7777, 3'b001, 0, 32'h0,        2};
        vecs[5] = '{32'h0000_7f20, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,        3'b000, 1, 32'h0,        1};
        vecs[6] = '{32'h0000_3ff0, 32'h0,        4'h0, 5, 32'h0BAD_F00D, 3'b001, 0, 32'h0BAD_F00D, 6};
        vecs[7] = '{32'h0000_4000, 32'h0,        4'h0, 0, 32'h0,        3'b000, 1, 32'h0,        1};

        cpu.cpu_req = 1'b0;
        cpu.cpu_addr = '0;
        cpu.cpu_wdata = '0;
        cpu.cpu_byteen = '0;
        set_ack(-1, '0);

        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;
        step();

        for (int i = 0; i < NVEC; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Stray acks from TC0 and a changing CPU request while DM is busy.
        cpu.cpu_req = 1'b1;
        cpu.cpu_addr = 32'h0000_0020;
        cpu.cpu_byteen = 4'h0;
        step();
        check("stray_sel", 32'(dev.dev_sel), 32'h1);
        cpu.cpu_req = 1'b0;
        cpu.cpu_addr = 32'h0000_9000;
        set_ack(1, 32'hBAD0_0001);
        step();
        check("stray_busy1", 32'(cpu.cpu_ready), 32'h0);
        check("stray_state", 32'(state), 32'(BUSY));
        check("stray_addr_held", dev.dev_addr, 32'h0000_0020);
        set_ack(1, 32'hBAD0_0002);
        step();
        check("stray_busy2", 32'(cpu.cpu_ready), 32'h0);
        set_ack(0, 32'h600D_CAFE);
        step();
        set_ack(-1, '0);
        check("stray_ready", 32'(cpu.cpu_ready), 32'h1);
        check("stray_err", 32'(cpu.cpu_err), 32'h0);
        check("stray_rdata", cpu.cpu_rdata, 32'h600D_CAFE);
        step();
        check("stray_idle", 32'(state), 32'(IDLE));

        // Asynchronous reset in the middle of a TC1 read.
        cpu.cpu_req = 1'b1;
        cpu.cpu_addr = 32'h0000_7f14;
        cpu.cpu_byteen = 4'h0;
        step();
        check("rst_pre_sel", 32'(dev.dev_sel), 32'h4);
        step();
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        cpu.cpu_req = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        run_txn(vecs[0], "post_rst");

`ifdef BRIDGE_TIMEOUT_EN
        // TC1 never answers: error in cycle 16, then a late ack must be ignored.
        cpu.cpu_req = 1'b1;
        cpu.cpu_addr = 32'h0000_7f14;
        cpu.cpu_byteen = 4'h0;
        step();
        early = 0;
        for (int c = 1; c < 16; c++) begin
            if (cpu.cpu_ready) early++;
            if (c == 15) check("to_last_busy", 32'(state), 32'(BUSY));
            step();
        end
        check("to_early_ready", 32'(early), 32'h0);
        check("to_ready", 32'(cpu.cpu_ready), 32'h1);
        check("to_err", 32'(cpu.cpu_err), 32'h1);
        check("to_rdata", cpu.cpu_rdata, 32'h0);
        check("to_sel_off", 32'(dev.dev_sel), 32'h0);
        cpu.cpu_req = 1'b0;
        step();
        set_ack(2, 32'hBEEF_0002);
        step();
        set_ack(-1, '0);
        check("late_ack_ready", 32'(cpu.cpu_ready), 32'h0);
        check("late_ack_state", 32'(state), 32'(IDLE));
        run_txn(vecs[0], "post_to");
`else
        // Without the timeout the bridge waits as long as the target needs.
        cpu.cpu_req = 1'b1;
        cpu.cpu_addr = 32'h0000_7f14;
        cpu.cpu_byteen = 4'h0;
        step();
        early = 0;
        for (int c = 1; c <= 40; c++) begin
            if (cpu.cpu_ready) early++;
            step();
        end
        check("wait_no_ready", 32'(early), 32'h0);
        check("wait_state", 32'(state), 32'(BUSY));
        check("wait_sel", 32'(dev.dev_sel), 32'h4);
        set_ack(2, 32'h5151_0002);
        step();
        set_ack(-1, '0);
        cpu.cpu_req = 1'b0;
        check("wait_ready", 32'(cpu.cpu_ready), 32'h1);
        check("wait_err", 32'(cpu.cpu_err), 32'h0);
        check("wait_rdata", cpu.cpu_rdata, 32'h5151_0002);
        step();
        run_txn(vecs[0], "post_wait");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
